// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the UART receive controller and its sampler, counter,
// deserializer and checker sub-blocks.
interface uart_rx_ctrl_if #(
  parameter int EDGE_W = 6
);
  logic              RX_IN;
  logic [EDGE_W-1:0] PRESCALE;
  logic [3:0]        DATA_LEN;
  logic              PAR_EN;
  logic              STOP2;
  logic [EDGE_W-1:0] EDGE_CNT;
  logic [3:0]        BIT_CNT;
  logic              STRT_GLITCH;
  logic              PAR_ERR;
  logic              STP_ERR;
  logic              DAT_SAMP_EN;
  logic              ENABLE;
  logic              DESER_EN;
  logic              STRT_CHK_EN;
  logic              PAR_CHK_EN;
  logic              STP_CHK_EN;
  logic              DATA_VALID;
  logic              PAR_ERR_O;
  logic              FRAME_ERR;
  logic              BREAK_DET;

  modport master (
    input  RX_IN, PRESCALE, DATA_LEN, PAR_EN, STOP2, EDGE_CNT, BIT_CNT,
           STRT_GLITCH, PAR_ERR, STP_ERR,
    output DAT_SAMP_EN, ENABLE, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
           DATA_VALID, PAR_ERR_O, FRAME_ERR, BREAK_DET
  );

  modport slave (
    output RX_IN, PRESCALE, DATA_LEN, PAR_EN, STOP2, EDGE_CNT, BIT_CNT,
           STRT_GLITCH, PAR_ERR, STP_ERR,
    input  DAT_SAMP_EN, ENABLE, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
           DATA_VALID, PAR_ERR_O, FRAME_ERR, BREAK_DET
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop phases,
// drives sub-block enables and reports valid frames, errors and line breaks.
module uart_rx_ctrl #(
  parameter int DATA_W = 9,
  parameter int EDGE_W = 6
) (
  input logic            CLK,
  input logic            RST,
  uart_rx_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    DATA   = 4'd2,
    PAR    = 4'd3,
    STOP_A = 4'd4,
    STOP_B = 4'd5,
    VALID  = 4'd6,
    BREAK  = 4'd7
  } state_t;

  localparam logic [3:0] MAX_LEN = 4'(DATA_W);
  localparam logic [3:0] MIN_LEN = 4'd5;

  state_t     state_reg;
  logic       line_low_reg;
  logic [3:0] len_reg;
  logic       par_en_reg;
  logic       stop2_reg;
  logic       par_err_o_reg;
  logic       frame_err_reg;

  logic       bit_end;
  logic       stop_end;
  logic [3:0] len_clamped;

  assign bit_end  = (bus.EDGE_CNT == bus.PRESCALE - EDGE_W'(1));
  assign stop_end = (bus.EDGE_CNT == bus.PRESCALE - EDGE_W'(2));

  always_comb begin
    len_clamped = bus.DATA_LEN;
    if (bus.DATA_LEN < MIN_LEN)
      len_clamped = MIN_LEN;
    else if (bus.DATA_LEN > MAX_LEN)
      len_clamped = MAX_LEN;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      line_low_reg  <= 1'b0;
      len_reg       <= 4'd0;
      par_en_reg    <= 1'b0;
      stop2_reg     <= 1'b0;
      par_err_o_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      par_err_o_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!bus.RX_IN) begin
            state_reg    <= START;
            line_low_reg <= 1'b1;
            len_reg      <= len_clamped;
            par_en_reg   <= bus.PAR_EN;
            stop2_reg    <= bus.STOP2;
          end
        end
        START: begin
          if (bit_end)
            state_reg <= bus.STRT_GLITCH ? IDLE : DATA;
        end
        DATA: begin
          if (bus.RX_IN)
            line_low_reg <= 1'b0;
          if (bit_end && bus.BIT_CNT == len_reg)
            state_reg <= par_en_reg ? PAR : STOP_A;
        end
        PAR: begin
          if (bus.RX_IN)
            line_low_reg <= 1'b0;
          if (bit_end) begin
            if (bus.PAR_ERR) begin
              state_reg     <= IDLE;
              par_err_o_reg <= 1'b1;
            end else begin
              state_reg <= STOP_A;
            end
          end
        end
        // With two stop bits the first one runs its full length; the last
        // stop bit finishes early so a back-to-back start edge is not missed.
        STOP_A: begin
          if (bus.RX_IN)
            line_low_reg <= 1'b0;
          if (stop2_reg ? bit_end : stop_end) begin
            if (bus.STP_ERR) begin
              if (line_low_reg) begin
                state_reg <= BREAK;
              end else begin
                state_reg     <= IDLE;
                frame_err_reg <= 1'b1;
              end
            end else begin
              state_reg <= stop2_reg ? STOP_B : VALID;
            end
          end
        end
        STOP_B: begin
          if (bus.RX_IN)
            line_low_reg <= 1'b0;
          if (stop_end) begin
            if (bus.STP_ERR) begin
              if (line_low_reg) begin
                state_reg <= BREAK;
              end else begin
                state_reg     <= IDLE;
                frame_err_reg <= 1'b1;
              end
            end else begin
              state_reg <= VALID;
            end
          end
        end
        VALID: begin
          if (!bus.RX_IN) begin
            state_reg    <= START;
            line_low_reg <= 1'b1;
            len_reg      <= len_clamped;
            par_en_reg   <= bus.PAR_EN;
            stop2_reg    <= bus.STOP2;
          end else begin
            state_reg <= IDLE;
          end
        end
        BREAK: begin
          if (bus.RX_IN)
            state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.DAT_SAMP_EN = 1'b0;
    bus.ENABLE      = 1'b0;
    bus.DESER_EN    = 1'b0;
    bus.STRT_CHK_EN = 1'b0;
    bus.PAR_CHK_EN  = 1'b0;
    bus.STP_CHK_EN  = 1'b0;
    bus.DATA_VALID  = 1'b0;
    bus.BREAK_DET   = 1'b0;
    case (state_reg)
      START: begin
        bus.DAT_SAMP_EN = 1'b1;
        bus.ENABLE      = 1'b1;
        bus.STRT_CHK_EN = 1'b1;
      end
      DATA: begin
        bus.DAT_SAMP_EN = 1'b1;
        bus.ENABLE      = 1'b1;
        bus.DESER_EN    = 1'b1;
      end
      PAR: begin
        bus.DAT_SAMP_EN = 1'b1;
        bus.ENABLE      = 1'b1;
        bus.PAR_CHK_EN  = 1'b1;
      end
      STOP_A, STOP_B: begin
        bus.DAT_SAMP_EN = 1'b1;
        bus.ENABLE      = 1'b1;
        bus.STP_CHK_EN  = 1'b1;
      end
      VALID:   bus.DATA_VALID = 1'b1;
      BREAK:   bus.BREAK_DET  = 1'b1;
      default: ;
    endcase
  end

  assign bus.PAR_ERR_O = par_err_o_reg;
  assign bus.FRAME_ERR = frame_err_reg;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: a table of serial frames with hand-computed
// pulse counts, timings and state decodes, plus a mid-frame reset sequence.
module tb_uart_rx_ctrl;
  localparam int EW = 6;
  localparam int P  = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  uart_rx_ctrl_if #(.EDGE_W(EW)) bus ();

  uart_rx_ctrl #(.DATA_W(9), .EDGE_W(EW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.master)
  );

  // Stand-in for the edge/bit counter sub-block: bit 0 is the start bit.
  logic [EW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST || !bus.ENABLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == bus.PRESCALE - EW'(1)) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end
  assign bus.EDGE_CNT = edge_cnt;
  assign bus.BIT_CNT  = bit_cnt;

  // {DAT_SAMP_EN, ENABLE, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN,
  //  DATA_VALID, PAR_ERR_O, FRAME_ERR, BREAK_DET}
  logic [9:0] outs;
  assign outs = {bus.DAT_SAMP_EN, bus.ENABLE, bus.DESER_EN, bus.STRT_CHK_EN,
                 bus.PAR_CHK_EN, bus.STP_CHK_EN, bus.DATA_VALID, bus.PAR_ERR_O,
                 bus.FRAME_ERR, bus.BREAK_DET};

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [3:0]  len;
    logic [3:0]  len_mid;
    logic        par_en;
    logic        stop2;
    logic [31:0] line;
    int          nbits;
    logic        glitch;
    logic        par_err;
    logic [15:0] stp_mask;
    int          probe_c;
    logic [9:0]  probe_o;
    int          exp_dv;
    int          exp_dv_at;
    int          exp_perr;
    int          exp_ferr;
    int          exp_brk;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string what, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", what, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int dv = 0, perr = 0, ferr = 0, brk = 0, dv_at = -1;
    logic [9:0] o4 = '0;
    logic [9:0] op = '0;
    bus.DATA_LEN    = v.len;
    bus.PAR_EN      = v.par_en;
    bus.STOP2       = v.stop2;
    bus.STRT_GLITCH = v.glitch;
    bus.PAR_ERR     = v.par_err;
    for (int c = 0; c < (v.nbits + 3) * P; c++) begin
      @(negedge CLK);
      if (bus.DATA_VALID) begin
        dv++;
        dv_at = c;
      end
      if (bus.PAR_ERR_O) perr++;
      if (bus.FRAME_ERR) ferr++;
      if (bus.BREAK_DET) brk++;
      if (c == 4) o4 = outs;
      if (c == v.probe_c) op = outs;
      if (c == 20) bus.DATA_LEN = v.len_mid;
      bus.RX_IN   = (c / P < v.nbits) ? v.line[c / P] : 1'b1;
      bus.STP_ERR = v.stp_mask[bit_cnt];
    end
    @(negedge CLK);
    check({v.name, " start_decode"}, int'(o4), int'(10'h340));
    check({v.name, " probe_decode"}, int'(op), int'(v.probe_o));
    check({v.name, " dv_count"}, dv, v.exp_dv);
    check({v.name, " dv_cycle"}, dv_at, v.exp_dv_at);
    check({v.name, " par_err_pulses"}, perr, v.exp_perr);
    check({v.name, " frame_err_pulses"}, ferr, v.exp_ferr);
    check({v.name, " break_cycles"}, brk, v.exp_brk);
    check({v.name, " idle_after"}, int'(outs), 0);
    $display("vec %s: dv=%0d at=%0d perr=%0d ferr=%0d brk=%0d", v.name, dv, dv_at, perr, ferr, brk);
    bus.STRT_GLITCH = 1'b0;
    bus.PAR_ERR     = 1'b0;
    bus.STP_ERR     = 1'b0;
  endtask

  initial begin
    int hits;
    //           name          len    mid    par   st2   line        nb  gl    pe    stp_mask    probe  probe_o   dv  at   pe fe brk
    vecs[0] = '{"basic_55",   4'd8,  4'd8,  1'b0, 1'b0, 32'h2AA,    10, 1'b0, 1'b0, 16'h0000,  76,   10'h310,  1,  80,  0, 0, 0};
    vecs[1] = '{"par_err",    4'd7,  4'd7,  1'b1, 1'b0, 32'h274,    10, 1'b0, 1'b1, 16'h0000,  68,   10'h320,  0,  -1,  1, 0, 0};
    vecs[2] = '{"stop2_ferr", 4'd8,  4'd8,  1'b0, 1'b1, 32'h386,    11, 1'b0, 1'b0, 16'h0400,  84,   10'h310,  0,  -1,  0, 1, 0};
    vecs[3] = '{"break",      4'd8,  4'd8,  1'b0, 1'b0, 32'h0,      12, 1'b0, 1'b0, 16'h0200,  90,   10'h001,  0,  -1,  0, 0, 17};
    vecs[4] = '{"glitch",     4'd8,  4'd8,  1'b0, 1'b0, 32'hFFFE,   10, 1'b1, 1'b0, 16'h0000,  20,   10'h000,  0,  -1,  0, 0, 0};
    vecs[5] = '{"clamp_lo",   4'd3,  4'd3,  1'b0, 1'b0, 32'h6A,     7,  1'b0, 1'b0, 16'h0000,  52,   10'h310,  1,  56,  0, 0, 0};
    vecs[6] = '{"clamp_hi",   4'd12, 4'd12, 1'b0, 1'b0, 32'h74A,    11, 1'b0, 1'b0, 16'h0000,  76,   10'h380,  1,  88,  0, 0, 0};
    vecs[7] = '{"par_stop2",  4'd6,  4'd6,  1'b1, 1'b1, 32'h35A,    10, 1'b0, 1'b0, 16'h0000,  60,   10'h320,  1,  80,  0, 0, 0};
    vecs[8] = '{"len_change", 4'd8,  4'd5,  1'b0, 1'b0, 32'h2AA,    10, 1'b0, 1'b0, 16'h0000,  76,   10'h310,  1,  80,  0, 0, 0};
    vecs[9] = '{"back2back",  4'd8,  4'd8,  1'b0, 1'b0, 32'h99AAA,  20, 1'b0, 1'b0, 16'h0000,  84,   10'h340,  2,  160, 0, 0, 0};

    RST             = 1'b1;
    bus.RX_IN       = 1'b1;
    bus.PRESCALE    = EW'(P);
    bus.DATA_LEN    = 4'd8;
    bus.PAR_EN      = 1'b0;
    bus.STOP2       = 1'b0;
    bus.STRT_GLITCH = 1'b0;
    bus.PAR_ERR     = 1'b0;
    bus.STP_ERR     = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_outs", int'(outs), 0);
    $display("reset: outs=0x%0h", outs);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("idle_outs", int'(outs), 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted in the middle of the data phase.
    bus.DATA_LEN = 4'd8;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLK);
      bus.RX_IN = vecs[0].line[c / P];
    end
    @(negedge CLK);
    check("pre_reset_data_decode", int'(outs), int'(10'h380));
    #2 RST = 1'b1;
    #1 check("async_reset_outs", int'(outs), 0);
    $display("mid-frame reset: outs=0x%0h", outs);
    @(negedge CLK);
    bus.RX_IN = 1'b1;
    @(negedge CLK);
    RST  = 1'b0;
    hits = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (outs != 10'h000) hits++;
    end
    check("post_reset_quiet", hits, 0);
    $display("post-reset idle: active cycles=%0d", hits);

    run_vec(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 9, meaning maximum data bits per frame (legal 5..9).
REQ-002 SHALL have parameter EDGE_W, default 6, meaning width of the oversampling edge counter and PRESCALE.
REQ-003 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RX_IN  input  1  raw serial line, idle high.
REQ-006 SHALL have port PRESCALE  input  EDGE_W  oversampling ratio (legal 4..2^EDGE_W-1).
REQ-007 SHALL have port DATA_LEN  input  4  data bits per frame.
REQ-008 SHALL have ports PAR_EN  input  1  parity bit present; and STOP2  input  1  two stop bits when high.
REQ-009 SHALL have ports EDGE_CNT  input  EDGE_W  and BIT_CNT  input  4, both from the edge/bit counter.
REQ-010 SHALL have ports STRT_GLITCH, PAR_ERR, STP_ERR  input  1 each, results from the checkers.
REQ-011 SHALL have ports DAT_SAMP_EN, ENABLE, DESER_EN, STRT_CHK_EN, PAR_CHK_EN, STP_CHK_EN  output  1 each, sub-block enables.
REQ-012 SHALL have ports DATA_VALID  output  1  frame accepted; PAR_ERR_O and FRAME_ERR  output  1  error pulses; BREAK_DET  output  1  line break present.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PAR, STOP_A, STOP_B, VALID and BREAK.
REQ-014 SHALL define bit_end as EDGE_CNT == PRESCALE-1 and stop_end as EDGE_CNT == PRESCALE-2.
REQ-015 SHALL latch DATA_LEN, PAR_EN and STOP2 on the IDLE->START or VALID->START transition; mid-frame changes SHALL be ignored.
REQ-016 SHALL clamp the latched length: DATA_LEN<5 becomes 5, DATA_LEN>DATA_W becomes DATA_W.
REQ-017 IDLE: RX_IN=0 -> START; otherwise stay in IDLE.
REQ-018 START: at bit_end, STRT_GLITCH=1 -> IDLE, else -> DATA.
REQ-019 DATA: at bit_end with BIT_CNT == latched length, -> PAR if parity is enabled, else -> STOP_A; otherwise stay in DATA.
REQ-020 PAR: at bit_end, PAR_ERR=1 -> IDLE and pulse PAR_ERR_O, else -> STOP_A.
REQ-021 STOP_A, single stop: at stop_end, STP_ERR=1 -> BREAK if line_low else -> IDLE with a FRAME_ERR pulse; STP_ERR=0 -> VALID.
REQ-022 STOP_A, two stops: at bit_end, the same STP_ERR handling as REQ-021 SHALL apply, except that STP_ERR=0 -> STOP_B.
REQ-023 STOP_B SHALL follow the REQ-021 rules at stop_end.
REQ-024 VALID: DATA_VALID=1 for exactly this one cycle; RX_IN=0 -> START (back-to-back frame), else -> IDLE.
REQ-025 BREAK: BREAK_DET=1; RX_IN=1 -> IDLE; no DATA_VALID or FRAME_ERR SHALL be issued.
REQ-026 line_low SHALL be an internal register set on entry to START and cleared on any cycle in DATA, PAR or a stop state with RX_IN=1.
REQ-027 DAT_SAMP_EN and ENABLE SHALL be 1 in START, DATA, PAR, STOP_A and STOP_B.
REQ-028 STRT_CHK_EN SHALL be 1 in START; DESER_EN in DATA; PAR_CHK_EN in PAR; STP_CHK_EN in STOP_A and STOP_B.
REQ-029 Enables, DATA_VALID and BREAK_DET SHALL be combinational decodes of the current state.
REQ-030 PAR_ERR_O and FRAME_ERR SHALL be registered and high for one cycle, the cycle after the erroring transition.
REQ-031 Illegal state encodings SHALL go to IDLE on the next clock with all outputs 0.
REQ-032 If bit_end and stop_end coincide in a state, the rule for that state's transition condition SHALL take precedence; no state SHALL act on both.

Reset
REQ-033 RST=1 SHALL force IDLE asynchronously and clear all outputs, line_low and the latched configuration to 0.
REQ-034 A reset mid-frame SHALL discard the frame with no DATA_VALID or error pulse; after RST falls, the block SHALL wait in IDLE for the next RX_IN=0.

Verification
REQ-035 PRESCALE=8, DATA_LEN=8, PAR_EN=0, STOP2=0, frame 0x55 -> DATA_VALID high for one cycle at stop bit EDGE_CNT=6, no errors.
REQ-036 DATA_LEN=7, PAR_EN=1, PAR_ERR=1 at the parity bit_end -> PAR_ERR_O pulses once, returns to IDLE, no DATA_VALID.
REQ-037 STOP2=1, second stop bit low with STP_ERR=1, earlier bits mixed -> FRAME_ERR pulses once, IDLE, no DATA_VALID.
REQ-038 RX_IN held low for 12 bit times, DATA_LEN=8 -> BREAK_DET stays high until RX_IN returns to 1, then IDLE; no FRAME_ERR.
REQ-039 STRT_GLITCH=1 at start bit_end -> IDLE, no enables asserted afterwards.
REQ-040 Two back-to-back frames with RX_IN=0 in VALID -> VALID->START directly, giving two DATA_VALID pulses.
REQ-041 DATA_LEN changed from 8 to 5 mid-frame -> the current frame completes with 8 data bits.
REQ-042 RST asserted in DATA -> all outputs 0 immediately.
